// File: rtl/intersection_light_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_light_sched_if
//  Description : Signal bundle for the intersection light scheduler.
//                The master side (environment or testbench) drives the
//                vehicle and pedestrian requests and observes the lamps.
//                The slave side (the scheduler) does the reverse.
//  Signals     : car_a, car_b, ped_req                      -> requests
//                a_green/a_yellow/a_red, b_green/b_yellow/b_red, walk_on
//                                                           -> lamps
//  Revision    : 1.0  initial release
// ============================================================================
interface intersection_light_sched_if;
    logic car_a;
    logic car_b;
    logic ped_req;
    logic a_green;
    logic a_yellow;
    logic a_red;
    logic b_green;
    logic b_yellow;
    logic b_red;
    logic walk_on;

    modport master (
        output car_a, car_b, ped_req,
        input  a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk_on
    );

    modport slave (
        input  car_a, car_b, ped_req,
        output a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk_on
    );
endinterface
`default_nettype wire

// File: rtl/intersection_light_sched.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_light_sched
//  Description : Moore FSM sequencing a two-direction intersection with a
//                pedestrian phase. Direction A rests in green until
//                direction B or a pedestrian asks for service; B gets a
//                fixed green; the walk phase follows the B all-red phase
//                when a pedestrian request is pending.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous active-high reset
//                bus    - slave modport of intersection_light_sched_if
//                         (requests in, lamps out)
//  Revision    : 1.0  initial release
// ============================================================================
module intersection_light_sched #(
    parameter int GREEN_CYCLES  = 4,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1,
    parameter int WALK_CYCLES   = 3
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    intersection_light_sched_if.slave        bus
);

    // ------------------------------------------------------------------
    // Timer sizing: wide enough to hold the largest (duration - 1).
    // ------------------------------------------------------------------
    localparam int c_MAX_GY  = (GREEN_CYCLES  > YELLOW_CYCLES) ? GREEN_CYCLES  : YELLOW_CYCLES;
    localparam int c_MAX_AW  = (ALLRED_CYCLES > WALK_CYCLES)   ? ALLRED_CYCLES : WALK_CYCLES;
    localparam int c_MAX_DUR = (c_MAX_GY > c_MAX_AW) ? c_MAX_GY : c_MAX_AW;
    localparam int c_TW      = (c_MAX_DUR > 1) ? $clog2(c_MAX_DUR) : 1;

    localparam logic [c_TW-1:0] c_GREEN_LAST  = c_TW'(GREEN_CYCLES  - 1);
    localparam logic [c_TW-1:0] c_YELLOW_LAST = c_TW'(YELLOW_CYCLES - 1);
    localparam logic [c_TW-1:0] c_ALLRED_LAST = c_TW'(ALLRED_CYCLES - 1);
    localparam logic [c_TW-1:0] c_WALK_LAST   = c_TW'(WALK_CYCLES   - 1);
    localparam logic [c_TW-1:0] c_TIMER_MAX   = {c_TW{1'b1}};

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_A_GREEN   = 3'd0;
    localparam logic [2:0] c_A_YELLOW  = 3'd1;
    localparam logic [2:0] c_ALLRED_AB = 3'd2;
    localparam logic [2:0] c_B_GREEN   = 3'd3;
    localparam logic [2:0] c_B_YELLOW  = 3'd4;
    localparam logic [2:0] c_ALLRED_BA = 3'd5;
    localparam logic [2:0] c_WALK      = 3'd6;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_TW-1:0] r_timer;
    logic            r_ped_pending;
    logic            w_state_chg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_A_GREEN: begin
                // A rests in green; only B traffic or a pedestrian ends it,
                // and only once the minimum green has elapsed. car_a never
                // matters here because A already holds the right of way.
                if ((r_timer >= c_GREEN_LAST) && (bus.car_b || r_ped_pending))
                    w_state_nxt = c_A_YELLOW;
            end
            c_A_YELLOW: begin
                if (r_timer == c_YELLOW_LAST)
                    w_state_nxt = c_ALLRED_AB;
            end
            c_ALLRED_AB: begin
                if (r_timer == c_ALLRED_LAST)
                    w_state_nxt = c_B_GREEN;
            end
            c_B_GREEN: begin
                if (r_timer == c_GREEN_LAST)
                    w_state_nxt = c_B_YELLOW;
            end
            c_B_YELLOW: begin
                if (r_timer == c_YELLOW_LAST)
                    w_state_nxt = c_ALLRED_BA;
            end
            c_ALLRED_BA: begin
                if (r_timer == c_ALLRED_LAST)
                    w_state_nxt = r_ped_pending ? c_WALK : c_A_GREEN;
            end
            c_WALK: begin
                if (r_timer == c_WALK_LAST)
                    w_state_nxt = c_A_GREEN;
            end
            default: w_state_nxt = c_A_GREEN;
        endcase
    end

    assign w_state_chg = (w_state_nxt != r_state);

    // ------------------------------------------------------------------
    // State, timer and pedestrian latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_A_GREEN;
            r_timer       <= '0;
            r_ped_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_chg)
                r_timer <= '0;
            else if (r_timer != c_TIMER_MAX)
                r_timer <= r_timer + 1'b1;

            // A new request on the edge that enters WALK is kept for the
            // following rotation, so the set term has priority.
            if (bus.ped_req)
                r_ped_pending <= 1'b1;
            else if (w_state_chg && (w_state_nxt == c_WALK))
                r_ped_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign bus.a_green  = (r_state == c_A_GREEN);
    assign bus.a_yellow = (r_state == c_A_YELLOW);
    assign bus.a_red    = (r_state != c_A_GREEN) && (r_state != c_A_YELLOW);
    assign bus.b_green  = (r_state == c_B_GREEN);
    assign bus.b_yellow = (r_state == c_B_YELLOW);
    assign bus.b_red    = (r_state != c_B_GREEN) && (r_state != c_B_YELLOW);
    assign bus.walk_on  = (r_state == c_WALK);

endmodule
`default_nettype wire

// File: tb/tb_intersection_light_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intersection_light_sched
//  Description : Directed testbench for intersection_light_sched with
//                hand-derived lamp timelines (default parameters).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_intersection_light_sched;

    localparam int AG = 0;  // A green,  B red
    localparam int AY = 1;  // A yellow, B red
    localparam int BG = 2;  // A red,    B green
    localparam int BY = 3;  // A red,    B yellow
    localparam int RR = 4;  // all red
    localparam int WK = 5;  // all red + walk

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    intersection_light_sched_if bus ();

    intersection_light_sched #(
        .GREEN_CYCLES  (4),
        .YELLOW_CYCLES (2),
        .ALLRED_CYCLES (1),
        .WALK_CYCLES   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lamp vector {a_green,a_yellow,a_red,b_green,b_yellow,b_red,walk_on}
    function automatic logic [6:0] lamps_of(input int code);
        case (code)
            AG:      return 7'b100_001_0;
            AY:      return 7'b010_001_0;
            BG:      return 7'b001_100_0;
            BY:      return 7'b001_010_0;
            RR:      return 7'b001_001_0;
            default: return 7'b001_001_1;
        endcase
    endfunction

    // One full rotation whose A yellow begins at cycle y (default timing):
    // AY y..y+1, RR y+2, BG y+3..y+6, BY y+7..y+8, RR y+9, then WALK for
    // three cycles (if a pedestrian is pending) or straight back to A green.
    function automatic int rot(input int c, input int y, input bit walk);
        if (c < y)        return AG;
        if (c <= y + 1)   return AY;
        if (c == y + 2)   return RR;
        if (c <= y + 6)   return BG;
        if (c <= y + 8)   return BY;
        if (c == y + 9)   return RR;
        if (walk && c <= y + 12) return WK;
        return AG;
    endfunction

    task automatic check_lamps(input string tag, input int cyc, input int code);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {bus.a_green, bus.a_yellow, bus.a_red,
               bus.b_green, bus.b_yellow, bus.b_red, bus.walk_on};
        exp = lamps_of(code);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle %0d lamps observed=%b expected=%b", tag, cyc, obs, exp);
        end
        checks++;
        assert ($onehot({bus.a_green, bus.a_yellow, bus.a_red}) &&
                $onehot({bus.b_green, bus.b_yellow, bus.b_red})) else begin
            failures++;
            $error("FAIL %s_onehot cycle %0d observed=%b expected one-hot per direction",
                   tag, cyc, obs);
        end
    endtask

    task automatic check_pending(input string tag, input logic exp);
        checks++;
        assert (dut.r_ped_pending === exp) else begin
            failures++;
            $error("FAIL %s ped_pending observed=%b expected=%b", tag, dut.r_ped_pending, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0 (reset just sampled low-going).
    task automatic do_reset();
        bus.car_a   = 1'b0;
        bus.car_b   = 1'b0;
        bus.ped_req = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.car_a   = 1'b0;
        bus.car_b   = 1'b0;
        bus.ped_req = 1'b0;

        // ---- Reset state, with requests active during reset ----------
        tick();
        bus.car_b   = 1'b1;
        bus.ped_req = 1'b1;
        tick();
        check_lamps("reset_hold", -1, AG);
        check_pending("reset_ped_discard", 1'b0);
        do_reset();

        // ---- Idle: A rests in green ---------------------------------
        for (int c = 0; c < 12; c++) begin
            bus.car_a = (c >= 6);   // car_a alone must not disturb A green
            check_lamps("idle", c, AG);
            tick();
        end

        // ---- car_b held: one rotation, no walk ---------------------
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            bus.car_b = (c <= 13);
            check_lamps("car_b_held", c, rot(c, 4, 1'b0));
            tick();
        end

        // ---- ped_req pulse at cycle 1, no cars ----------------------
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            bus.ped_req = (c == 1);
            check_lamps("ped_pulse", c, rot(c, 4, 1'b1));
            if (c == 2)  check_pending("ped_set", 1'b1);
            if (c == 17) check_pending("ped_clear", 1'b0);
            tick();
        end

        // ---- car_b single-cycle pulse at cycle 9 --------------------
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            bus.car_b = (c == 9);
            check_lamps("car_b_pulse", c, rot(c, 10, 1'b0));
            tick();
        end

        // ---- Reset inside B_GREEN with a pending pedestrian ---------
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            bus.ped_req = (c == 1);
            check_lamps("pre_reset", c, rot(c, 4, 1'b1));
            tick();
        end
        check_pending("pre_reset_pending", 1'b1);
        reset       = 1'b1;
        bus.ped_req = 1'b1;   // must be discarded
        tick();
        reset       = 1'b0;
        bus.ped_req = 1'b0;
        check_lamps("after_reset", 0, AG);
        check_pending("after_reset_pending", 1'b0);
        for (int c = 0; c <= 17; c++) begin
            bus.car_b = (c <= 3);
            check_lamps("post_reset_rot", c, rot(c, 4, 1'b0));
            tick();
        end

        // ---- ped_req during WALK is kept for the next rotation ------
        do_reset();
        for (int c = 0; c <= 36; c++) begin
            bus.ped_req = (c == 1) || (c == 15);
            check_lamps("ped_in_walk", c, (c < 17) ? rot(c, 4, 1'b1) : rot(c, 21, 1'b1));
            if (c == 17) check_pending("ped_retained", 1'b1);
            if (c == 34) check_pending("ped_second_clear", 1'b0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
